// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: blank code, scan FSM
// states and the slot-length helper.
package seg_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      GUARD,
      DRIVE
   } scan_state_t;

   function automatic int ticks_per_slot(input int clk_hz, input int refresh_hz);
      return clk_hz / refresh_hz;
   endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Clearable modulo-TICKS slot counter. guard_end marks the last guard cycle of a
// slot, tick marks the last cycle of the slot.
module refresh_prescaler
   import seg_pkg::*;
#(
   parameter int TICKS        = 10,
   parameter int GUARD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick,
   output logic guard_end
);

   localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(TICKS - 1);
   localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD_CYCLES - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (clr || (cnt_reg == LAST_CNT)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign tick      = (cnt_reg == LAST_CNT);
   assign guard_end = (cnt_reg == GUARD_CNT);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display
// with tear-free (frame-boundary) value updates and leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int CLK_HZ       = 100_000_000,
   parameter int REFRESH_HZ   = 1_000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  blank_lz,
   output logic [3:0]            bcd_out,
   output logic                  dp_out,
   output logic [N_DIGITS-1:0]   an_n,
   output logic                  frame_done
);

   localparam int TICKS = ticks_per_slot(CLK_HZ, REFRESH_HZ);
   localparam int IW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

   if ((TICKS < GUARD_CYCLES + 2) || (N_DIGITS < 1)) begin : g_bad_params
      $fatal(1, "seg_scan_ctrl: need TICKS >= GUARD_CYCLES+2 and N_DIGITS >= 1");
   end

   scan_state_t             state_reg, state_next;
   logic [IW-1:0]           idx_reg, idx_next;
   logic [4*N_DIGITS-1:0]   disp_reg, pend_reg;
   logic [N_DIGITS-1:0]     disp_dp_reg, pend_dp_reg;
   logic                    pend_flag_reg;
   logic [N_DIGITS-1:0]     an_n_reg, an_n_next;
   logic [3:0]              bcd_reg, bcd_next;
   logic                    dp_reg, dp_next;
   logic                    frame_done_reg;
   logic                    frame_end;
   logic                    presc_clr;
   logic                    tick;
   logic                    guard_end;
   logic [N_DIGITS-1:0]     zero_above;
   logic                    zero_run;
   logic [3:0]              digit_code [N_DIGITS];

   refresh_prescaler #(
      .TICKS       (TICKS),
      .GUARD_CYCLES(GUARD_CYCLES)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clr      (presc_clr),
      .tick     (tick),
      .guard_end(guard_end)
   );

   // zero_above[i]: digit i and every more-significant digit are zero
   always_comb begin
      zero_run   = 1'b1;
      zero_above = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run      = zero_run && (disp_reg[4*i +: 4] == 4'd0);
         zero_above[i] = zero_run;
      end
   end

   for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib = disp_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
         assign digit_code[gi] = (nib > 4'd9) ? BLANK_CODE : nib;
      end else begin : g_upper
         assign digit_code[gi] = ((nib > 4'd9) || (blank_lz && zero_above[gi])) ? BLANK_CODE : nib;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      presc_clr  = 1'b0;
      frame_end  = 1'b0;
      case (state_reg)
         IDLE: begin
            presc_clr = 1'b1;
            if (enable) begin
               state_next = GUARD;
               idx_next   = '0;
            end
         end
         GUARD: begin
            if (guard_end) state_next = DRIVE;
         end
         DRIVE: begin
            if (tick) begin
               state_next = GUARD;
               frame_end  = (idx_reg == LAST_IDX);
               idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // Dropping enable abandons any partial slot and darkens the display
      if (!enable) begin
         state_next = IDLE;
         idx_next   = '0;
         presc_clr  = 1'b1;
         frame_end  = 1'b0;
      end

      an_n_next = '1;
      bcd_next  = BLANK_CODE;
      dp_next   = 1'b1;
      if (state_next == DRIVE) begin
         an_n_next[idx_next] = 1'b0;
         bcd_next            = digit_code[idx_next];
         dp_next             = ~disp_dp_reg[idx_next];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         an_n_reg       <= '1;
         bcd_reg        <= BLANK_CODE;
         dp_reg         <= 1'b1;
         frame_done_reg <= 1'b0;
         disp_reg       <= '0;
         disp_dp_reg    <= '0;
         pend_reg       <= '0;
         pend_dp_reg    <= '0;
         pend_flag_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         an_n_reg       <= an_n_next;
         bcd_reg        <= bcd_next;
         dp_reg         <= dp_next;
         frame_done_reg <= frame_end;

         // While dark there is nothing to tear, so updates land immediately
         if ((state_reg == IDLE) || frame_end) begin
            if (load) begin
               disp_reg    <= digits_in;
               disp_dp_reg <= dp_in;
            end else if (pend_flag_reg) begin
               disp_reg    <= pend_reg;
               disp_dp_reg <= pend_dp_reg;
            end
            pend_flag_reg <= 1'b0;
         end else if (load) begin
            pend_reg      <= digits_in;
            pend_dp_reg   <= dp_in;
            pend_flag_reg <= 1'b1;
         end
      end
   end

   assign an_n       = an_n_reg;
   assign bcd_out    = bcd_reg;
   assign dp_out     = dp_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: expected slot contents are queued when the
// stimulus is applied and compared as each lit slot appears.
module tb_seg_scan_ctrl;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          load;
   logic [15:0]   digits_in;
   logic [3:0]    dp_in;
   logic          blank_lz;
   logic [3:0]    bcd_out;
   logic          dp_out;
   logic [3:0]    an_n;
   logic          frame_done;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] bcd;
      logic       dp;
   } exp_t;

   exp_t       sb[$];
   int         n_total = 0;
   int         n_pass  = 0;
   int         cyc     = 0;
   int         last_fd = 0;
   logic [3:0] cur_an;

   seg_scan_ctrl #(
      .N_DIGITS    (N),
      .CLK_HZ      (1000),
      .REFRESH_HZ  (100),
      .GUARD_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .load      (load),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .blank_lz  (blank_lz),
      .bcd_out   (bcd_out),
      .dp_out    (dp_out),
      .an_n      (an_n),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic [15:0] v, input logic [3:0] dp, input bit blz,
                                  input int dig);
      exp_t       m;
      logic [3:0]  nib   = v[4*dig +: 4];
      logic [15:0] upper = v >> (4 * dig);
      bit          blank = (nib > 4'd9) || (blz && dig > 0 && upper == 16'd0);
      m.an  = ~(4'b0001 << dig);
      m.bcd = blank ? 4'hF : nib;
      m.dp  = ~dp[dig];
      return m;
   endfunction

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input bit blz);
      for (int d = 0; d < N; d++) sb.push_back(model(v, dp, blz, d));
   endtask

   // Wait for the next lit slot; dark0 = dark samples already seen
   task automatic wait_lit(input int dark0);
      int   dark = dark0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (an_n !== 4'hF) break;
         dark++;
         if (dark > 100) break;
      end
      cur_an = an_n;
      chk("guard_len", dark, 2);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         $display("slot an_n=%b bcd=%h dp=%b (exp an_n=%b bcd=%h dp=%b)",
                  an_n, bcd_out, dp_out, e.an, e.bcd, e.dp);
         chk("an_n", an_n, e.an);
         chk("bcd_out", bcd_out, e.bcd);
         chk("dp_out", dp_out, e.dp);
      end
   endtask

   // Follow the lit slot to its end; optionally load during its final cycle
   task automatic wait_dark(input bit late, input logic [15:0] v, input logic [3:0] dp);
      int lit = 1;
      forever begin
         if (late && lit == 8) begin
            digits_in = v;
            dp_in     = dp;
            load      = 1'b1;
         end
         @(negedge clk);
         load = 1'b0;
         if (an_n !== cur_an) break;
         lit++;
         if (lit > 50) break;
      end
      chk("lit_len", lit, 8);
      chk("dark_an", an_n, 4'hF);
      chk("dark_bcd", bcd_out, 4'hF);
      chk("frame_done", frame_done, (cur_an == 4'b0111));
      if (frame_done === 1'b1) begin
         if (last_fd != 0) chk("fd_period", cyc - last_fd, 40);
         last_fd = cyc;
      end
   endtask

   task automatic mid_load(input logic [15:0] v, input logic [3:0] dp);
      digits_in = v;
      dp_in     = dp;
      load      = 1'b1;
   endtask

   task automatic check_dark(input string tag);
      chk({tag, "_an"}, an_n, 4'hF);
      chk({tag, "_bcd"}, bcd_out, 4'hF);
      chk({tag, "_dp"}, dp_out, 1'b1);
      chk({tag, "_fd"}, frame_done, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      load      = 1'b0;
      digits_in = '0;
      dp_in     = '0;
      blank_lz  = 1'b0;
      repeat (2) @(negedge clk);
      check_dark("reset");
      rst = 1'b0;

      // 1: load while idle, then scan 1234
      @(negedge clk);
      mid_load(16'h1234, 4'b0000);
      @(negedge clk);
      load   = 1'b0;
      enable = 1'b1;
      push_frame(16'h1234, 4'b0000, 1'b0);
      wait_lit(0); wait_dark(0, '0, '0);
      for (int d = 1; d < N; d++) begin wait_lit(1); wait_dark(0, '0, '0); end

      // 2: load during digit 1 is deferred to the frame boundary
      push_frame(16'h1234, 4'b0000, 1'b0);
      wait_lit(1); wait_dark(0, '0, '0);
      wait_lit(1); mid_load(16'h5678, 4'b0000); wait_dark(0, '0, '0);
      wait_lit(1); wait_dark(0, '0, '0);
      wait_lit(1); wait_dark(0, '0, '0);

      // two loads in one frame: only the last one shows
      push_frame(16'h5678, 4'b0000, 1'b0);
      wait_lit(1); mid_load(16'h1111, 4'b1111); wait_dark(0, '0, '0);
      wait_lit(1); wait_dark(0, '0, '0);
      wait_lit(1); mid_load(16'h4321, 4'b0000); wait_dark(0, '0, '0);
      wait_lit(1); wait_dark(0, '0, '0);

      // load in the apply cycle goes straight to the display
      push_frame(16'h4321, 4'b0000, 1'b0);
      for (int d = 0; d < N - 1; d++) begin wait_lit(1); wait_dark(0, '0, '0); end
      wait_lit(1); wait_dark(1, 16'h0040, 4'b0100);
      blank_lz = 1'b1;

      // 3: leading-zero blanking with decimal points
      push_frame(16'h0040, 4'b0100, 1'b1);
      wait_lit(1); mid_load(16'h0000, 4'b0000); wait_dark(0, '0, '0);
      for (int d = 1; d < N; d++) begin wait_lit(1); wait_dark(0, '0, '0); end

      push_frame(16'h0000, 4'b0000, 1'b1);
      wait_lit(1); mid_load(16'h9A0B, 4'b0000); wait_dark(0, '0, '0);
      for (int d = 1; d < N; d++) begin wait_lit(1); wait_dark(0, '0, '0); end

      // 4: non-BCD nibbles blank; 5: drop enable during digit 2
      push_frame(16'h9A0B, 4'b0000, 1'b1);
      wait_lit(1); wait_dark(0, '0, '0);
      wait_lit(1); wait_dark(0, '0, '0);
      wait_lit(1);
      enable = 1'b0;
      @(negedge clk);
      check_dark("disable");
      sb.delete();
      last_fd = 0;
      repeat (3) @(negedge clk);
      chk("idle_an", an_n, 4'hF);
      enable = 1'b1;
      sb.push_back(model(16'h9A0B, 4'b0000, 1'b1, 0));
      sb.push_back(model(16'h9A0B, 4'b0000, 1'b1, 1));
      wait_lit(0); wait_dark(0, '0, '0);
      wait_lit(1);

      // 6: asynchronous reset between edges mid-DRIVE
      #2 rst = 1'b1;
      #1 check_dark("async_rst");
      @(negedge clk);
      rst     = 1'b0;
      last_fd = 0;
      sb.push_back(model(16'h0000, 4'b0000, 1'b1, 0));
      wait_lit(0); wait_dark(0, '0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
